pipe_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage integer pipeline. Generates per-stage enable/flush strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, covering:
- load-use hazards
- EX-resolved redirects
- instruction-fetch wait states
- data-memory wait states

A small FSM discards the wrong-path fetch that is still in flight when a redirect occurs. MEM->EX and WB->EX forwarding is handled by the forwarding unit, not here.

---
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: per-stage enable/flush strobes, redirect drain FSM.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  input  logic              imem_ready,
  input  logic              dmem_busy,
  output logic              pc_en,
  output logic              pc_sel_redirect,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_flush,
  output logic [1:0]        ctrl_state,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  state_t w_eval_state;
  logic   r_pending;
  logic   w_next_pending;
  logic   w_load_use;

  logic w_pc_en;
  logic w_pc_sel_redirect;
  logic w_if_id_en;
  logic w_if_id_flush;
  logic w_id_ex_en;
  logic w_id_ex_flush;
  logic w_ex_mem_en;
  logic w_mem_wb_flush;

  function automatic logic f_load_use(
    input logic              mem_read,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs1,
    input logic              rs1_used,
    input logic [REG_AW-1:0] rs2,
    input logic              rs2_used
  );
    return mem_read && (rd != '0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

  assign w_load_use = f_load_use(ex_mem_read, ex_rd, id_rs1, id_rs1_used,
                                 id_rs2, id_rs2_used);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_next_pending;
    end
  end

  // Leaving MEM_WAIT, the cycle is evaluated as the state that was interrupted.
  always_comb begin
    case (r_state)
      ST_DRAIN:    w_eval_state = ST_DRAIN;
      ST_MEM_WAIT: w_eval_state = r_pending ? ST_DRAIN : ST_RUN;
      default:     w_eval_state = ST_RUN;
    endcase
  end

  always_comb begin
    w_pc_en           = 1'b1;
    w_pc_sel_redirect = 1'b0;
    w_if_id_en        = 1'b1;
    w_if_id_flush     = 1'b0;
    w_id_ex_en        = 1'b1;
    w_id_ex_flush     = 1'b0;
    w_ex_mem_en       = 1'b1;
    w_mem_wb_flush    = 1'b0;
    w_next_state      = r_state;
    w_next_pending    = r_pending;

    if (dmem_busy) begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_flush = 1'b1;
      w_next_state   = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT)
        w_next_pending = (r_state == ST_DRAIN);
    end else begin
      w_next_pending = 1'b0;
      case (w_eval_state)
        ST_DRAIN: begin
          // PC already holds the target; the late wrong-path response is dropped.
          w_pc_en       = 1'b0;
          w_if_id_flush = 1'b1;
          w_next_state  = imem_ready ? ST_RUN : ST_DRAIN;
        end
        default: begin
          w_next_state = ST_RUN;
          if (ex_br_taken) begin
            w_pc_sel_redirect = 1'b1;
            w_if_id_flush     = 1'b1;
            w_id_ex_flush     = 1'b1;
            if (!imem_ready)
              w_next_state = ST_DRAIN;
          end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            w_pc_en       = 1'b0;
            w_if_id_flush = 1'b1;
          end
        end
      endcase
    end
  end

  // Reset forces the safe strobe set asynchronously, independent of the clock.
  assign pc_en           = w_pc_en           & ~rst;
  assign pc_sel_redirect = w_pc_sel_redirect & ~rst;
  assign if_id_en        = w_if_id_en        & ~rst;
  assign if_id_flush     = w_if_id_flush     |  rst;
  assign id_ex_en        = w_id_ex_en        & ~rst;
  assign id_ex_flush     = w_id_ex_flush     |  rst;
  assign ex_mem_en       = w_ex_mem_en       & ~rst;
  assign mem_wb_flush    = w_mem_wb_flush    |  rst;
  assign ctrl_state      = r_state;

`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  function automatic logic [PERF_W-1:0] f_sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en)
        r_stall_cnt <= f_sat_inc(r_stall_cnt);
      if (w_pc_sel_redirect)
        r_flush_cnt <= f_sat_inc(r_flush_cnt);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven, scoreboarded bench for pipe_hazard_ctrl, plus hand-written reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_br_taken, imem_ready, dmem_busy;
  logic          pc_en, pc_sel_redirect, if_id_en, if_id_flush;
  logic          id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic [1:0]    ctrl_state;
  logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(5), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush), .ctrl_state(ctrl_state),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // Strobe bits: {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [7:0] NORM = 8'b1010_1010;
  localparam logic [7:0] RSTV = 8'b0001_0101;
  localparam logic [7:0] P1   = 8'b0000_0001;
  localparam logic [7:0] BR   = 8'b1111_1110;
  localparam logic [7:0] LU   = 8'b0000_1110;
  localparam logic [7:0] IFW  = 8'b0011_1010;

  typedef struct {
    logic       busy, br, imr, mr;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [7:0] exp_s;
    logic [1:0] exp_st;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic [1:0] st;
    int         idx;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [7:0] strobes();
    return {pc_en, pc_sel_redirect, if_id_en, if_id_flush,
            id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic busy, input logic br, input logic imr, input logic mr,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [7:0] s, input logic [1:0] st);
    vec_t v;
    v.busy = busy; v.br = br; v.imr = imr; v.mr = mr;
    v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exp_s = s; v.exp_st = st;
    tbl.push_back(v);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0;
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check($sformatf("vec%0d strobes", e.idx), 32'(strobes()), 32'(e.s));
      check($sformatf("vec%0d state", e.idx), 32'(ctrl_state), 32'(e.st));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_stall, exp_flush;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset strobes", 32'(strobes()), 32'(RSTV));
    check("reset state", 32'(ctrl_state), 0);
    check("reset stall_cnt", 32'(perf_stall_cnt), 0);
    check("reset flush_cnt", 32'(perf_flush_cnt), 0);

    //  busy br imr mr rd rs1 u1 rs2 u2  strobes state
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 0 idle
    add(0, 0, 1, 1, 5, 0, 0, 5, 1, LU,   0);  // 1 load-use on rs2
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, NORM, 0);  // 2 rd=0 never stalls
    add(0, 0, 1, 1, 7, 7, 1, 0, 0, LU,   0);  // 3 load-use on rs1
    add(0, 0, 1, 1, 7, 7, 0, 0, 0, NORM, 0);  // 4 rs1 not read
    add(0, 0, 1, 0, 7, 7, 1, 0, 0, NORM, 0);  // 5 not a load
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, BR,   0);  // 6 redirect, fetch ready
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 7 stays RUN
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, IFW,  0);  // 8 fetch wait
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, BR,   0);  // 9 redirect, fetch outstanding
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, IFW,  2);  // 10
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, IFW,  2);  // 11
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, IFW,  2);  // 12 discard response
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 13 refetch
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, BR,   0);  // 14 enter DRAIN
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, P1,   2);  // 15 mem busy over DRAIN
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, P1,   1);  // 16
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, P1,   1);  // 17
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, IFW,  1);  // 18 exit evaluates as DRAIN
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, IFW,  2);  // 19
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, IFW,  2);  // 20
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 21
    add(1, 1, 1, 1, 5, 0, 0, 5, 1, P1,   0);  // 22 busy beats branch and load-use
    add(1, 1, 1, 1, 5, 0, 0, 5, 1, P1,   1);  // 23
    add(0, 1, 1, 1, 5, 0, 0, 5, 1, BR,   1);  // 24 branch retaken on release
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 25
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, P1,   0);  // 26
    add(0, 0, 1, 1, 5, 0, 0, 5, 1, LU,   1);  // 27 exit evaluates as RUN
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 28
    add(0, 0, 0, 1, 5, 0, 0, 5, 1, LU,   0);  // 29 load-use beats fetch wait
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 30
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, BR,   0);  // 31
    add(0, 0, 0, 1, 5, 0, 0, 5, 1, IFW,  2);  // 32 no load-use in DRAIN
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, IFW,  2);  // 33 branch ignored in DRAIN
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0);  // 34

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      sb_t e;
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b0;
      dmem_busy = tbl[i].busy; ex_br_taken = tbl[i].br; imem_ready = tbl[i].imr;
      ex_mem_read = tbl[i].mr; ex_rd = tbl[i].rd;
      id_rs1 = tbl[i].rs1; id_rs1_used = tbl[i].u1;
      id_rs2 = tbl[i].rs2; id_rs2_used = tbl[i].u2;
      e.s = tbl[i].exp_s; e.st = tbl[i].exp_st; e.idx = i;
      sbq.push_back(e);
      if (!tbl[i].exp_s[7]) exp_stall++;
      if (tbl[i].exp_s[6])  exp_flush++;
    end
    @(posedge clk);
    #1;
    idle();
    check("scoreboard drained", 32'(sbq.size()), 0);
`ifdef PIPE_HAZARD_PERF_EN
    if (exp_stall > (1 << PW) - 1) exp_stall = (1 << PW) - 1;
    if (exp_flush > (1 << PW) - 1) exp_flush = (1 << PW) - 1;
`else
    exp_stall = 0;
    exp_flush = 0;
`endif
    check("perf_stall_cnt", 32'(perf_stall_cnt), 32'(exp_stall));
    check("perf_flush_cnt", 32'(perf_flush_cnt), 32'(exp_flush));

    // Asynchronous reset asserted in the middle of a DRAIN cycle.
    @(posedge clk);
    #1;
    ex_br_taken = 1'b1; imem_ready = 1'b0;
    @(posedge clk);
    #1;
    ex_br_taken = 1'b0;
    #2;
    check("drain before reset", 32'(ctrl_state), 2);
    rst = 1'b1;
    #1;
    check("async reset strobes", 32'(strobes()), 32'(RSTV));
    check("async reset state", 32'(ctrl_state), 0);
    check("async reset stall_cnt", 32'(perf_stall_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ready = 1'b1;
    #3;
    check("post-reset strobes", 32'(strobes()), 32'(NORM));
    check("post-reset state", 32'(ctrl_state), 0);
    @(posedge clk);
    #1;
    check("post-reset state next", 32'(ctrl_state), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
